instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 29 ++
 rtl/instr_fetch.sv | 113 +++++++++++
 tb/tb_instr_fetch.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Bundles the program-load, control and fetch-output signals of instr_fetch.
// Carries no logic of its own, so it adds no latency.
// There is no backpressure: stall is a plain level input driven by the CPU side.
interface instr_fetch_if #(
    parameter int AW = 4
);
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [8:0]    load_data;
    logic          start;
    logic [AW-1:0] end_addr;
    logic          stall;
    logic [8:0]    Instruction;
    logic [AW-1:0] pc;
    logic          valid;
    logic          done;

    // Host/CPU side: loads the program, starts it and consumes fetched words.
    modport master (
        output load_en, load_addr, load_data, start, end_addr, stall,
        input  Instruction, pc, valid, done
    );

    // Fetch unit side.
    modport slave (
        input  load_en, load_addr, load_data, start, end_addr, stall,
        output Instruction, pc, valid, done
    );
endinterface

// File: rtl/instr_fetch.sv
// Program store plus sequencer that streams words 0..end_addr to the CPU.
// start at edge k gives the first word after edge k+1, then one word per cycle.
// stall inserts a NOP bubble and holds pc; load/start are ignored while running.
module instr_fetch #(
    parameter logic [8:0] NOP_WORD = 9'b000000000,
    parameter int         AW       = 4
) (
    input  logic          CLK,
    input  logic          RST,
    instr_fetch_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_nxt;
    logic [AW-1:0] r_end;
    logic [AW-1:0] w_end_nxt;
    logic [8:0]    r_instr;
    logic [8:0]    w_instr_nxt;
    logic          r_valid;
    logic          w_valid_nxt;
    logic          r_done;
    logic          w_done_nxt;
    logic          w_mem_we;
    logic [8:0]    w_rd_word;

    // Program memory has no reset so a reset never loses the loaded program.
    logic [8:0]    r_mem [2**AW];

    assign w_rd_word = r_mem[r_pc];

    // Next-state and next-output decode; every output defaults to a bubble.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_end_nxt   = r_end;
        w_instr_nxt = NOP_WORD;
        w_valid_nxt = 1'b0;
        w_done_nxt  = r_done;
        w_mem_we    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                // A write wins over start when both arrive together.
                if (bus.load_en) begin
                    w_mem_we    = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b0;
                end else if (bus.start) begin
                    w_end_nxt   = bus.end_addr;
                    w_pc_nxt    = '0;
                    w_state_nxt = S_RUN;
                    w_done_nxt  = 1'b0;
                end else if (r_state == S_DONE) begin
                    w_done_nxt  = 1'b1;
                end
            end
            S_RUN: begin
                if (!bus.stall) begin
                    w_instr_nxt = w_rd_word;
                    w_valid_nxt = 1'b1;
                    // pc parks on the last word rather than wrapping.
                    if (r_pc == r_end) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_pc_nxt = r_pc + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset overrides every other input.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_end   <= '0;
            r_instr <= NOP_WORD;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_end   <= w_end_nxt;
            r_instr <= w_instr_nxt;
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Synchronous program write, suppressed while reset is asserted.
    always_ff @(posedge CLK) begin
        if (!RST && w_mem_we) begin
            r_mem[bus.load_addr] <= bus.load_data;
        end
    end

    assign bus.Instruction = r_instr;
    assign bus.pc          = r_pc;
    assign bus.valid       = r_valid;
    assign bus.done        = r_done;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
    localparam int         AW  = 4;
    localparam logic [8:0] NOP = 9'b000000000;
    localparam logic [8:0] W0  = 9'b100111110;
    localparam logic [8:0] W1  = 9'b100100011;
    localparam logic [8:0] W2  = 9'b000101101;
    localparam logic [8:0] W3  = 9'b110011011;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_if #(.AW(AW)) bus ();

    instr_fetch #(.NOP_WORD(NOP), .AW(AW)) u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: the program is snapshotted into a queue at start and
    // handed out one word per unstalled cycle; mode 0 idle, 1 run, 2 done.
    logic [8:0] m_mem [16];
    logic [8:0] m_prog [$];
    int         m_mode = 0;
    int         m_pc   = 0;
    logic [8:0] e_instr = NOP;
    bit         e_valid = 1'b0;
    bit         e_done  = 1'b0;

    typedef struct {
        bit         rst;
        bit         le;
        logic [3:0] la;
        logic [8:0] ld;
        bit         st;
        logic [3:0] ea;
        bit         sl;
        logic [8:0] instr;
        logic [3:0] pc;
        bit         valid;
        bit         done;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(bit r, bit le, logic [3:0] la, logic [8:0] ld, bit st,
                                logic [3:0] ea, bit sl, logic [8:0] ins, logic [3:0] p,
                                bit v, bit d);
        vec_t t;
        t.rst = r; t.le = le; t.la = la; t.ld = ld; t.st = st; t.ea = ea; t.sl = sl;
        t.instr = ins; t.pc = p; t.valid = v; t.done = d;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit le, input logic [3:0] la, input logic [8:0] ld,
                         input bit st, input logic [3:0] ea, input bit sl);
        rst           = r;
        bus.load_en   = le;
        bus.load_addr = la;
        bus.load_data = ld;
        bus.start     = st;
        bus.end_addr  = ea;
        bus.stall     = sl;
    endtask

    task automatic idle();
        drive(0, 0, 4'd0, 9'd0, 0, 4'd0, 0);
    endtask

    task automatic model_step();
        if (rst) begin
            m_mode = 0; m_pc = 0; m_prog.delete();
            e_instr = NOP; e_valid = 0; e_done = 0;
        end else if (m_mode == 1) begin
            e_instr = NOP; e_valid = 0;
            if (!bus.stall) begin
                e_instr = m_prog.pop_front();
                e_valid = 1;
                if (m_prog.size() == 0) m_mode = 2;
                else m_pc++;
            end
        end else begin
            e_instr = NOP; e_valid = 0;
            if (bus.load_en) begin
                m_mem[bus.load_addr] = bus.load_data;
                m_mode = 0; e_done = 0;
            end else if (bus.start) begin
                m_prog.delete();
                for (int i = 0; i <= int'(bus.end_addr); i++) m_prog.push_back(m_mem[i]);
                m_pc = 0; m_mode = 1; e_done = 0;
            end else if (m_mode == 2) begin
                e_done = 1;
            end
        end
    endtask

    // One clock: model advances on the edge, DUT is sampled 1ns later.
    task automatic tick();
        logic [3:0] epc;
        @(posedge clk);
        model_step();
        #1;
        epc = m_pc[3:0];
        chk("model", {17'd0, bus.Instruction, bus.pc, bus.valid, bus.done},
                     {17'd0, e_instr, epc, e_valid, e_done});
    endtask

    initial begin
        int nvalid;
        drive(1, 0, 4'd0, 9'd0, 0, 4'd0, 0);

        tbl[0]  = mk(1,0,4'd0,9'd0,  0,4'd0,0, NOP,4'd0,0,0);
        tbl[1]  = mk(0,1,4'd0,W0,    0,4'd0,0, NOP,4'd0,0,0);
        tbl[2]  = mk(0,1,4'd1,W1,    0,4'd0,0, NOP,4'd0,0,0);
        tbl[3]  = mk(0,1,4'd2,W2,    0,4'd0,0, NOP,4'd0,0,0);
        tbl[4]  = mk(0,1,4'd3,W3,    0,4'd0,0, NOP,4'd0,0,0);
        tbl[5]  = mk(0,0,4'd0,9'd0,  1,4'd3,0, NOP,4'd0,0,0);
        tbl[6]  = mk(0,0,4'd0,9'd0,  0,4'd0,0, W0, 4'd1,1,0);
        tbl[7]  = mk(0,0,4'd0,9'd0,  0,4'd0,0, W1, 4'd2,1,0);
        tbl[8]  = mk(0,0,4'd0,9'd0,  0,4'd0,0, W2, 4'd3,1,0);
        tbl[9]  = mk(0,0,4'd0,9'd0,  0,4'd0,0, W3, 4'd3,1,0);
        tbl[10] = mk(0,0,4'd0,9'd0,  0,4'd0,0, NOP,4'd3,0,1);
        tbl[11] = mk(0,0,4'd0,9'd0,  0,4'd0,1, NOP,4'd3,0,1);
        tbl[12] = mk(0,0,4'd0,9'd0,  1,4'd3,0, NOP,4'd0,0,0);
        tbl[13] = mk(0,0,4'd0,9'd0,  0,4'd0,0, W0, 4'd1,1,0);
        tbl[14] = mk(0,0,4'd0,9'd0,  0,4'd0,0, W1, 4'd2,1,0);
        tbl[15] = mk(0,0,4'd0,9'd0,  0,4'd0,1, NOP,4'd2,0,0);
        tbl[16] = mk(0,0,4'd0,9'd0,  0,4'd0,0, W2, 4'd3,1,0);
        tbl[17] = mk(0,0,4'd0,9'd0,  0,4'd0,0, W3, 4'd3,1,0);
        tbl[18] = mk(0,0,4'd0,9'd0,  0,4'd0,0, NOP,4'd3,0,1);
        tbl[19] = mk(0,1,4'd5,9'h0AA,1,4'd3,0, NOP,4'd3,0,0);
        tbl[20] = mk(0,0,4'd0,9'd0,  0,4'd0,0, NOP,4'd3,0,0);

        // Directed table: reset, load, basic run, stalled run, load+start.
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].rst, tbl[i].le, tbl[i].la, tbl[i].ld, tbl[i].st, tbl[i].ea, tbl[i].sl);
            tick();
            chk($sformatf("tbl%0d", i),
                {17'd0, bus.Instruction, bus.pc, bus.valid, bus.done},
                {17'd0, tbl[i].instr, tbl[i].pc, tbl[i].valid, tbl[i].done});
        end

        // end_addr = 0: one valid word, done two edges after start.
        drive(0, 0, 4'd0, 9'd0, 1, 4'd0, 0); tick();
        idle(); tick();
        chk("ea0_word", {22'd0, bus.Instruction, bus.valid}, {22'd0, W0, 1'b1});
        tick();
        chk("ea0_done", {30'd0, bus.valid, bus.done}, {30'd0, 1'b0, 1'b1});

        // Reset after the second word aborts; restart reuses retained memory.
        drive(0, 0, 4'd0, 9'd0, 1, 4'd3, 0); tick();
        idle(); tick(); tick();
        chk("pre_rst_w1", {22'd0, bus.Instruction, bus.valid}, {22'd0, W1, 1'b1});
        drive(1, 0, 4'd0, 9'd0, 1, 4'd3, 1); tick();
        chk("rst_abort", {26'd0, bus.pc, bus.valid, bus.done}, 32'd0);
        drive(0, 0, 4'd0, 9'd0, 1, 4'd3, 0); tick();
        idle(); tick();
        chk("restart_w0", {22'd0, bus.Instruction, bus.valid}, {22'd0, W0, 1'b1});
        for (int i = 0; i < 4; i++) tick();

        // Write attempt during RUN must not reach memory.
        drive(0, 0, 4'd0, 9'd0, 1, 4'd3, 0); tick();
        drive(0, 1, 4'd1, 9'h1FF, 0, 4'd0, 0); tick();
        idle();
        for (int i = 0; i < 4; i++) tick();
        drive(0, 0, 4'd0, 9'd0, 1, 4'd3, 0); tick();
        idle(); tick(); tick();
        chk("run_write_ignored", {23'd0, bus.Instruction}, {23'd0, W1});
        for (int i = 0; i < 3; i++) tick();

        // Full-depth program: 16 words, pc parks at 15.
        for (int a = 0; a < 16; a++) begin
            drive(0, 1, a[3:0], 9'($urandom_range(0, 511)), 0, 4'd0, 0); tick();
        end
        drive(0, 0, 4'd0, 9'd0, 1, 4'd15, 0); tick();
        idle();
        nvalid = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus.valid) nvalid++;
        end
        chk("full_nvalid", nvalid, 16);
        chk("full_pc", {28'd0, bus.pc}, 32'd15);
        tick();
        chk("full_done", {30'd0, bus.pc == 4'd15, bus.done}, {30'd0, 1'b1, 1'b1});

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 59) == 0,
                  $urandom_range(0, 7) == 0,
                  4'($urandom_range(0, 15)),
                  9'($urandom_range(0, 511)),
                  $urandom_range(0, 9) == 0,
                  4'($urandom_range(0, 15)),
                  $urandom_range(0, 3) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
